// File: rtl/arrow_key_tracker.sv
// PS/2 byte-stream parser: decodes E0/F0 prefixes, tracks four extended keys,
// and publishes press/release strobes plus the last completed scancode.
module arrow_key_tracker #(
   parameter logic [7:0] KEY_LEFT       = 8'h6B,
   parameter logic [7:0] KEY_DOWN       = 8'h72,
   parameter logic [7:0] KEY_RIGHT      = 8'h74,
   parameter logic [7:0] KEY_UP         = 8'h75,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic [3:0]  keys,
   output logic [3:0]  press_pulse,
   output logic [3:0]  release_pulse,
   output logic [15:0] scancode,
   output logic        scancode_break,
   output logic        scancode_valid,
   output logic        err
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : CW'(0);
   localparam logic [7:0] BYTE_EXT = 8'hE0;
   localparam logic [7:0] BYTE_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [3:0]    keys_r, keys_s;
   logic [3:0]    press_r, press_s;
   logic [3:0]    release_r, release_s;
   logic [15:0]   scancode_r, scancode_s;
   logic          brk_r, brk_s;
   logic          valid_r, valid_s;
   logic          err_r, err_s;
   logic [3:0]    hit_s;
   logic          is_prefix_s;

   // Lowest bit index wins when key codes collide, so the result is one-hot or zero.
   function automatic logic [3:0] key_match(input logic [7:0] b);
      logic [3:0] m;
      if (b == KEY_LEFT) begin
         m = 4'b0001;
      end else if (b == KEY_DOWN) begin
         m = 4'b0010;
      end else if (b == KEY_RIGHT) begin
         m = 4'b0100;
      end else if (b == KEY_UP) begin
         m = 4'b1000;
      end else begin
         m = 4'b0000;
      end
      return m;
   endfunction

   assign hit_s       = key_match(byte_in);
   assign is_prefix_s = (byte_in == BYTE_EXT) || (byte_in == BYTE_BRK);

   // Next-state, key tracking, strobe generation and prefix timeout.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      keys_s     = keys_r;
      press_s    = 4'b0000;
      release_s  = 4'b0000;
      scancode_s = scancode_r;
      brk_s      = brk_r;
      valid_s    = 1'b0;
      err_s      = 1'b0;
      if (byte_valid) begin
         cnt_s = CW'(0);
         case (state_r)
            ST_IDLE: begin
               if (byte_in == BYTE_EXT) begin
                  state_s = ST_EXT;
               end else if (byte_in == BYTE_BRK) begin
                  state_s = ST_BRK;
               end else begin
                  scancode_s = {8'h00, byte_in};
                  brk_s      = 1'b0;
                  valid_s    = 1'b1;
               end
            end
            ST_EXT: begin
               if (byte_in == BYTE_BRK) begin
                  state_s = ST_EXT_BRK;
               end else if (byte_in == BYTE_EXT) begin
                  state_s = ST_EXT;
               end else begin
                  scancode_s = {BYTE_EXT, byte_in};
                  brk_s      = 1'b0;
                  valid_s    = 1'b1;
                  state_s    = ST_IDLE;
                  // A typematic repeat of a held key produces no new press.
                  if ((hit_s & ~keys_r) != 4'b0000) begin
                     keys_s  = keys_r | hit_s;
                     press_s = hit_s;
                  end else begin
                     keys_s = keys_r;
                  end
               end
            end
            ST_BRK: begin
               state_s = ST_IDLE;
               if (is_prefix_s) begin
                  err_s = 1'b1;
               end else begin
                  scancode_s = {8'h00, byte_in};
                  brk_s      = 1'b1;
                  valid_s    = 1'b1;
               end
            end
            ST_EXT_BRK: begin
               state_s = ST_IDLE;
               if (is_prefix_s) begin
                  err_s = 1'b1;
               end else begin
                  scancode_s = {BYTE_EXT, byte_in};
                  brk_s      = 1'b1;
                  valid_s    = 1'b1;
                  if ((hit_s & keys_r) != 4'b0000) begin
                     keys_s    = keys_r & ~hit_s;
                     release_s = hit_s;
                  end else begin
                     keys_s = keys_r;
                  end
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end else if ((TIMEOUT_CYCLES != 0) && (state_r != ST_IDLE)) begin
         if (cnt_r == TO_LAST) begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
            cnt_s   = CW'(0);
         end else begin
            cnt_s = cnt_r + CW'(1);
         end
      end else begin
         cnt_s = CW'(0);
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= CW'(0);
         keys_r     <= 4'b0000;
         press_r    <= 4'b0000;
         release_r  <= 4'b0000;
         scancode_r <= 16'h0000;
         brk_r      <= 1'b0;
         valid_r    <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         keys_r     <= keys_s;
         press_r    <= press_s;
         release_r  <= release_s;
         scancode_r <= scancode_s;
         brk_r      <= brk_s;
         valid_r    <= valid_s;
         err_r      <= err_s;
      end
   end

   assign keys           = keys_r;
   assign press_pulse    = press_r;
   assign release_pulse  = release_r;
   assign scancode       = scancode_r;
   assign scancode_break = brk_r;
   assign scancode_valid = valid_r;
   assign err            = err_r;

endmodule

// File: tb/tb_arrow_key_tracker.sv
// Bench for arrow_key_tracker: directed vector table, reset/timeout sequences,
// and random byte streams compared against a prefix-queue reference model.
module tb_arrow_key_tracker;

   localparam int TO = 16;
   localparam logic [7:0] E0 = 8'hE0;
   localparam logic [7:0] F0 = 8'hF0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic [3:0]  keys, press_pulse, release_pulse;
   logic [15:0] scancode;
   logic        scancode_break, scancode_valid, err;

   arrow_key_tracker #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
      .keys(keys), .press_pulse(press_pulse), .release_pulse(release_pulse),
      .scancode(scancode), .scancode_break(scancode_break),
      .scancode_valid(scancode_valid), .err(err)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Reference model: pending prefix bytes, idle count, held keys, last outputs.
   logic [7:0]  pend[$];
   int          m_idle;
   logic [7:0]  codes[4];
   logic [3:0]  m_keys, m_press, m_rel;
   logic [15:0] m_sc;
   logic        m_brk, m_sv, m_err;

   function automatic int key_index(input logic [7:0] b);
      for (int i = 0; i < 4; i++)
         if (codes[i] == b) return i;
      return -1;
   endfunction

   task automatic model_reset();
      pend.delete();
      m_idle = 0;
      m_keys = 4'b0; m_press = 4'b0; m_rel = 4'b0;
      m_sc = 16'h0; m_brk = 1'b0; m_sv = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic [7:0] b);
      int k;
      bit ext;
      m_press = 4'b0; m_rel = 4'b0; m_sv = 1'b0; m_err = 1'b0;
      k = key_index(b);
      if (v) begin
         m_idle = 0;
         if (pend.size() == 0) begin
            if (b == E0 || b == F0) pend.push_back(b);
            else begin m_sc = {8'h00, b}; m_brk = 1'b0; m_sv = 1'b1; end
         end else if (pend.size() == 1 && pend[0] == E0) begin
            if (b == F0) pend.push_back(b);
            else if (b != E0) begin
               m_sc = {E0, b}; m_brk = 1'b0; m_sv = 1'b1;
               if (k >= 0 && !m_keys[k]) begin m_keys[k] = 1'b1; m_press[k] = 1'b1; end
               pend.delete();
            end
         end else begin
            ext = (pend[0] == E0);
            if (b == E0 || b == F0) m_err = 1'b1;
            else begin
               m_sc = {ext ? E0 : 8'h00, b}; m_brk = 1'b1; m_sv = 1'b1;
               if (ext && k >= 0 && m_keys[k]) begin m_keys[k] = 1'b0; m_rel[k] = 1'b1; end
            end
            pend.delete();
         end
      end else if (pend.size() != 0) begin
         m_idle++;
         if (m_idle == TO) begin m_err = 1'b1; pend.delete(); m_idle = 0; end
      end
   endtask

   function automatic logic [30:0] dut_vec();
      return {keys, press_pulse, release_pulse, scancode, scancode_break, scancode_valid, err};
   endfunction

   task automatic check(input string name, input logic [30:0] act, input logic [30:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (keys|press|rel|scancode|brk|valid|err)", name, act, exp);
   endtask

   // One clock: drive at negedge, advance the model, sample 1ns after posedge.
   task automatic step(input logic v, input logic [7:0] b);
      @(negedge clk);
      byte_valid = v;
      byte_in = b;
      model_step(v, b);
      @(posedge clk);
      #1;
      check("model", dut_vec(), {m_keys, m_press, m_rel, m_sc, m_brk, m_sv, m_err});
   endtask

   typedef struct {
      logic        v;
      logic [7:0]  b;
      logic [3:0]  k, p, r;
      logic [15:0] sc;
      logic        brk, sv, er;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic v, input logic [7:0] b, input logic [3:0] k, input logic [3:0] p,
                      input logic [3:0] r, input logic [15:0] sc, input logic brk, input logic sv,
                      input logic er);
      vec_t t;
      t.v = v; t.b = b; t.k = k; t.p = p; t.r = r; t.sc = sc; t.brk = brk; t.sv = sv; t.er = er;
      tbl.push_back(t);
   endtask

   initial begin
      codes[0] = 8'h6B; codes[1] = 8'h72; codes[2] = 8'h74; codes[3] = 8'h75;
      model_reset();

      // left make / break
      add(1, E0,    4'b0000, 4'b0000, 4'b0000, 16'h0000, 0, 0, 0);
      add(1, 8'h6B, 4'b0001, 4'b0001, 4'b0000, 16'hE06B, 0, 1, 0);
      add(0, 8'h00, 4'b0001, 4'b0000, 4'b0000, 16'hE06B, 0, 0, 0);
      add(1, E0,    4'b0001, 4'b0000, 4'b0000, 16'hE06B, 0, 0, 0);
      add(1, F0,    4'b0001, 4'b0000, 4'b0000, 16'hE06B, 0, 0, 0);
      add(1, 8'h6B, 4'b0000, 4'b0000, 4'b0001, 16'hE06B, 1, 1, 0);
      // typematic up, then right, then release up
      add(1, E0,    4'b0000, 4'b0000, 4'b0000, 16'hE06B, 1, 0, 0);
      add(1, 8'h75, 4'b1000, 4'b1000, 4'b0000, 16'hE075, 0, 1, 0);
      add(1, E0,    4'b1000, 4'b0000, 4'b0000, 16'hE075, 0, 0, 0);
      add(1, 8'h75, 4'b1000, 4'b0000, 4'b0000, 16'hE075, 0, 1, 0);
      add(1, E0,    4'b1000, 4'b0000, 4'b0000, 16'hE075, 0, 0, 0);
      add(1, 8'h75, 4'b1000, 4'b0000, 4'b0000, 16'hE075, 0, 1, 0);
      add(1, E0,    4'b1000, 4'b0000, 4'b0000, 16'hE075, 0, 0, 0);
      add(1, 8'h74, 4'b1100, 4'b0100, 4'b0000, 16'hE074, 0, 1, 0);
      add(1, E0,    4'b1100, 4'b0000, 4'b0000, 16'hE074, 0, 0, 0);
      add(1, F0,    4'b1100, 4'b0000, 4'b0000, 16'hE074, 0, 0, 0);
      add(1, 8'h75, 4'b0100, 4'b0000, 4'b1000, 16'hE075, 1, 1, 0);
      // non-extended make and break leave keys alone
      add(1, 8'h6B, 4'b0100, 4'b0000, 4'b0000, 16'h006B, 0, 1, 0);
      add(1, F0,    4'b0100, 4'b0000, 4'b0000, 16'h006B, 0, 0, 0);
      add(1, 8'h6B, 4'b0100, 4'b0000, 4'b0000, 16'h006B, 1, 1, 0);
      // protocol errors
      add(1, F0,    4'b0100, 4'b0000, 4'b0000, 16'h006B, 1, 0, 0);
      add(1, E0,    4'b0100, 4'b0000, 4'b0000, 16'h006B, 1, 0, 1);
      add(1, E0,    4'b0100, 4'b0000, 4'b0000, 16'h006B, 1, 0, 0);
      add(1, F0,    4'b0100, 4'b0000, 4'b0000, 16'h006B, 1, 0, 0);
      add(1, F0,    4'b0100, 4'b0000, 4'b0000, 16'h006B, 1, 0, 1);
      // release of an unheld key
      add(1, E0,    4'b0100, 4'b0000, 4'b0000, 16'h006B, 1, 0, 0);
      add(1, F0,    4'b0100, 4'b0000, 4'b0000, 16'h006B, 1, 0, 0);
      add(1, 8'h72, 4'b0100, 4'b0000, 4'b0000, 16'hE072, 1, 1, 0);
      // repeated E0 prefix is tolerated
      add(1, E0,    4'b0100, 4'b0000, 4'b0000, 16'hE072, 1, 0, 0);
      add(1, E0,    4'b0100, 4'b0000, 4'b0000, 16'hE072, 1, 0, 0);
      add(1, 8'h6B, 4'b0101, 4'b0001, 4'b0000, 16'hE06B, 0, 1, 0);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset", dut_vec(), 31'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].b);
         check($sformatf("vec%0d", i), dut_vec(),
               {tbl[i].k, tbl[i].p, tbl[i].r, tbl[i].sc, tbl[i].brk, tbl[i].sv, tbl[i].er});
      end

      // prefix timeout: err on the 16th idle cycle, then back in IDLE
      step(1, E0);
      for (int i = 0; i < TO - 1; i++) step(0, 8'h00);
      step(0, 8'h00);
      check("timeout_err", {31'(err)}, 31'd1);
      step(1, 8'h74);
      check("after_timeout", {16'(scancode), 15'(keys)}, {16'h0074, 15'd5});

      // byte on the expiry cycle wins
      step(1, E0);
      for (int i = 0; i < TO - 1; i++) step(0, 8'h00);
      step(1, 8'h72);
      check("expiry_byte", dut_vec(), {4'b0111, 4'b0010, 4'b0000, 16'hE072, 1'b0, 1'b1, 1'b0});

      // reset mid-prefix
      step(1, E0);
      @(negedge clk);
      rst_n = 1'b0;
      byte_valid = 1'b0;
      model_reset();
      #1;
      check("reset_mid_prefix", dut_vec(), 31'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 8'h6B);
      check("post_reset_make", dut_vec(), {4'b0000, 4'b0000, 4'b0000, 16'h006B, 1'b0, 1'b1, 1'b0});

      // random streams against the model
      for (int n = 0; n < 3000; n++) begin
         int r;
         logic [7:0] b;
         r = int'($urandom_range(0, 19));
         if (r == 0) begin
            int len;
            len = int'($urandom_range(10, 20));
            for (int j = 0; j < len; j++) step(0, 8'($urandom));
         end else if (r < 6) begin
            step(0, 8'($urandom));
         end else begin
            r = int'($urandom_range(0, 9));
            if (r < 3) b = E0;
            else if (r < 5) b = F0;
            else if (r < 9) b = codes[$urandom_range(0, 3)];
            else b = 8'($urandom);
            step(1, b);
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/arrow_key_tracker.md
Name: arrow_key_tracker

Overview:
- Sequential successor to the team's combinational arrow-key scancode decoder.
- Consumes a raw PS/2 byte stream (from the PS/2 receiver) one byte at a time.
- Parses E0 (extended) and F0 (break) prefixes and tracks held/released state for four configurable extended keys.
- Emits per-key press/release pulses plus the last assembled 16-bit scancode for downstream game/UI logic.

Parameters:
- KEY_LEFT, 8'h6B, low byte of the extended code mapped to keys[0].
- KEY_DOWN, 8'h72, low byte of the extended code mapped to keys[1].
- KEY_RIGHT, 8'h74, low byte of the extended code mapped to keys[2].
- KEY_UP, 8'h75, low byte of the extended code mapped to keys[3].
- TIMEOUT_CYCLES, 1000000, idle cycles allowed inside a prefix before abort; 0 disables the timeout.
- The counter width is a localparam, $clog2(TIMEOUT_CYCLES+1), minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- byte_in  in  8  received PS/2 data byte.
- byte_valid  in  1  one-cycle strobe: byte_in is valid this cycle.
- keys  out  4  held state {up,right,down,left}; 1 = currently pressed.
- press_pulse  out  4  one-cycle strobe on a key's 0->1 transition.
- release_pulse  out  4  one-cycle strobe on a key's 1->0 transition.
- scancode  out  16  last completed code: {8'hE0 or 8'h00, code byte}.
- scancode_break  out  1  1 if the last completed code was a break.
- scancode_valid  out  1  one-cycle strobe when scancode/scancode_break update.
- err  out  1  one-cycle strobe on a protocol violation or timeout.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FSM in IDLE, timeout counter 0.
- All outputs are registered; every strobe is asserted the cycle after the accepting byte_valid cycle.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - Any other byte completes a make: scancode={00,b}, scancode_break=0, scancode_valid=1, stay IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT, restart timer, no err.
  - Other byte b: make, scancode={E0,b}.
    - If b matches a KEY_* parameter and that key is 0: set it, press_pulse for that bit.
    - If the key is already 1 (typematic repeat): keys unchanged, no pulse, scancode_valid still 1.
    - Return to IDLE.
- BRK:
  - E0 or F0 -> err=1, go IDLE, no scancode_valid.
  - Other byte b: scancode={00,b}, scancode_break=1, scancode_valid=1, go IDLE. keys unaffected; non-extended codes never touch keys.
- EXT_BRK:
  - E0 or F0 -> err=1, go IDLE.
  - Other byte b: scancode={E0,b}, scancode_break=1, scancode_valid=1.
    - If b matches a key that is held: clear it, release_pulse for that bit.
    - If b matches a key that is not held: no pulse.
    - Go IDLE.
- Timeout:
  - Counter clears on every byte_valid and runs only in EXT/BRK/EXT_BRK.
  - On reaching TIMEOUT_CYCLES with no byte: err=1, go IDLE, keys unchanged.
  - If byte_valid arrives in the same cycle the counter would expire, the byte wins: it is processed in the current state and no err is raised.
- If KEY_* parameters collide, the lowest bit index wins; only one key changes per code.
- At most one bit of press_pulse/release_pulse is set in any cycle.
- press_pulse and release_pulse are never both set in the same cycle.
- keys holds its value indefinitely between codes.

Test Plan:
- Reset mid-prefix: send E0, assert rst_n=0 for 1 cycle -> all outputs 0. Then send 6B -> scancode=16'h006B, keys=0000.
- Extended make/break of left: E0,6B -> keys=0001, press_pulse=0001, scancode=16'hE06B, scancode_break=0. Then E0,F0,6B -> keys=0000, release_pulse=0001, scancode_break=1.
- Typematic and multi-key: E0,75 three times -> one press_pulse=1000, three scancode_valid strobes. Then E0,74 -> keys=1100. Releasing 75 -> keys=0100.
- Non-extended code: 6B then F0,6B -> scancode=16'h006B make then break, keys stays 0000, no press/release pulses.
- Protocol errors: F0,E0 -> err=1, FSM IDLE, no scancode_valid. E0,F0,F0 -> err=1. Release of an unheld key E0,F0,72 -> no release_pulse.
- Timeout (TIMEOUT_CYCLES=16): E0 then idle 16 cycles -> err=1, IDLE. Next byte arriving exactly on the expiry cycle -> processed, no err.
